// File: rtl/trap_pkg.sv
// Shared constants and types for the trap sequencer.
// CSR addresses, cause codes, mstatus fields and FSM states.
package trap_pkg;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  localparam int unsigned CAUSE_ILLEGAL = 2;
  localparam int unsigned CAUSE_BREAK   = 3;
  localparam int unsigned CAUSE_ECALL_M = 11;

  localparam int MIE_BIT  = 3;
  localparam int MPIE_BIT = 7;
  localparam int MPP_HI   = 12;
  localparam int MPP_LO   = 11;

  localparam logic [1:0] CSR_OP_RW = 2'b01;

  typedef enum logic [2:0] {
    S_IDLE,
    S_W_MEPC,
    S_W_MCAUSE,
    S_W_MSTATUS,
    S_R_MSTATUS,
    S_REDIRECT
  } trap_state_e;

endpackage

// File: rtl/trap_cause_enc.sv
// Priority encoder for retire-time trap events.
// illegal > ebreak > ecall > mret; lower events are discarded.
module trap_cause_enc
  import trap_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            ecall,
  input  logic            ebreak,
  input  logic            illegal,
  input  logic            mret,
  output logic            take,
  output logic            is_mret,
  output logic [XLEN-1:0] cause
);

  // Pick the highest-priority flag and its cause code
  always_comb begin
    take    = 1'b1;
    is_mret = 1'b0;
    cause   = '0;
    if (illegal) begin
      cause = XLEN'(CAUSE_ILLEGAL);
    end else if (ebreak) begin
      cause = XLEN'(CAUSE_BREAK);
    end else if (ecall) begin
      cause = XLEN'(CAUSE_ECALL_M);
    end else if (mret) begin
      is_mret = 1'b1;
    end else begin
      take = 1'b0;
    end
  end

endmodule

// File: rtl/trap_ctrl.sv
// Trap sequencer and owner of the CSR write port.
// Passes instruction writes through when idle, else sequences traps.
module trap_ctrl
  import trap_pkg::*;
#(
  parameter int         XLEN              = 32,
  parameter logic [1:0] RESET_MSTATUS_MPP = 2'b11
) (
  input  logic            i_clk,
  input  logic            i_rst_n,
  input  logic            i_valid,
  input  logic [XLEN-1:0] i_pc,
  input  logic            i_ecall,
  input  logic            i_ebreak,
  input  logic            i_illegal,
  input  logic            i_mret,
  input  logic            i_inst_csr_we,
  input  logic [11:0]     i_inst_csr_addr,
  input  logic [1:0]      i_inst_csr_op,
  input  logic [XLEN-1:0] i_inst_csr_wdata,
  input  logic [XLEN-1:0] i_mtvec,
  input  logic [XLEN-1:0] i_mepc,
  input  logic [XLEN-1:0] i_mstatus,
  output logic            o_csr_we,
  output logic [11:0]     o_csr_addr,
  output logic [1:0]      o_csr_op,
  output logic [XLEN-1:0] o_csr_wdata,
  output logic            o_stall,
  output logic            o_redirect_valid,
  input  logic            i_redirect_ready,
  output logic [XLEN-1:0] o_redirect_pc,
  output logic            o_busy
);

  trap_state_e     state;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] r_cause;
  logic            r_is_mret;

  logic            take;
  logic            is_mret;
  logic [XLEN-1:0] cause;
  logic            idle;
  logic            accept;
  logic [XLEN-1:0] ms_trap;
  logic [XLEN-1:0] ms_mret;
  logic [XLEN-1:0] vec_base;
  logic            unused_mtvec;

  trap_cause_enc #(
    .XLEN(XLEN)
  ) u_enc (
    .ecall  (i_ecall),
    .ebreak (i_ebreak),
    .illegal(i_illegal),
    .mret   (i_mret),
    .take   (take),
    .is_mret(is_mret),
    .cause  (cause)
  );

  assign idle     = (state == S_IDLE);
  assign accept   = idle & i_rst_n & i_valid & take;
  assign o_stall  = ~idle | accept;
  assign o_busy   = ~idle;
  assign vec_base = {i_mtvec[XLEN-1:2], 2'b00};

  // Mode bits are direct-only, so the low mtvec bits are ignored
  assign unused_mtvec = ^i_mtvec[1:0];

  // New mstatus images for trap entry and mret
  always_comb begin
    ms_trap = i_mstatus;
    ms_trap[MPIE_BIT] = i_mstatus[MIE_BIT];
    ms_trap[MIE_BIT] = 1'b0;
    ms_trap[MPP_HI:MPP_LO] = RESET_MSTATUS_MPP;
    ms_mret = i_mstatus;
    ms_mret[MIE_BIT] = i_mstatus[MPIE_BIT];
    ms_mret[MPIE_BIT] = 1'b1;
    ms_mret[MPP_HI:MPP_LO] = RESET_MSTATUS_MPP;
  end

  // Sequencer state and latched trap context
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state     <= S_IDLE;
      r_pc      <= '0;
      r_cause   <= '0;
      r_is_mret <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (accept) begin
            r_pc      <= i_pc;
            r_cause   <= cause;
            r_is_mret <= is_mret;
            state     <= is_mret ? S_R_MSTATUS : S_W_MEPC;
          end
        end
        S_W_MEPC:    state <= S_W_MCAUSE;
        S_W_MCAUSE:  state <= S_W_MSTATUS;
        S_W_MSTATUS: state <= S_REDIRECT;
        S_R_MSTATUS: state <= S_REDIRECT;
        S_REDIRECT: begin
          if (i_redirect_ready) state <= S_IDLE;
        end
        default:     state <= S_IDLE;
      endcase
    end
  end

  // Write port and redirect decode from the current state
  always_comb begin
    o_csr_we         = 1'b0;
    o_csr_addr       = '0;
    o_csr_op         = '0;
    o_csr_wdata      = '0;
    o_redirect_valid = 1'b0;
    o_redirect_pc    = '0;
    unique case (state)
      S_IDLE: begin
        if (i_rst_n && !accept) begin
          o_csr_we    = i_inst_csr_we;
          o_csr_addr  = i_inst_csr_addr;
          o_csr_op    = i_inst_csr_op;
          o_csr_wdata = i_inst_csr_wdata;
        end
      end
      S_W_MEPC: begin
        o_csr_we    = 1'b1;
        o_csr_addr  = CSR_MEPC;
        o_csr_op    = CSR_OP_RW;
        o_csr_wdata = r_pc;
      end
      S_W_MCAUSE: begin
        o_csr_we    = 1'b1;
        o_csr_addr  = CSR_MCAUSE;
        o_csr_op    = CSR_OP_RW;
        o_csr_wdata = r_cause;
      end
      S_W_MSTATUS: begin
        o_csr_we    = 1'b1;
        o_csr_addr  = CSR_MSTATUS;
        o_csr_op    = CSR_OP_RW;
        o_csr_wdata = ms_trap;
      end
      S_R_MSTATUS: begin
        o_csr_we    = 1'b1;
        o_csr_addr  = CSR_MSTATUS;
        o_csr_op    = CSR_OP_RW;
        o_csr_wdata = ms_mret;
      end
      S_REDIRECT: begin
        o_redirect_valid = 1'b1;
        o_redirect_pc    = r_is_mret ? i_mepc : vec_base;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_trap_ctrl.sv
// Directed bench for trap_ctrl.
// Hand-computed expectations checked each cycle.
module tb_trap_ctrl;

  logic        clk;
  logic        rst_n;
  logic        valid;
  logic [31:0] pc;
  logic        ecall;
  logic        ebreak;
  logic        illegal;
  logic        mret;
  logic        iwe;
  logic [11:0] iaddr;
  logic [1:0]  iop;
  logic [31:0] iwdata;
  logic [31:0] mtvec;
  logic [31:0] mepc;
  logic [31:0] mstatus;
  logic        csr_we;
  logic [11:0] csr_addr;
  logic [1:0]  csr_op;
  logic [31:0] csr_wdata;
  logic        stall;
  logic        rv;
  logic        rready;
  logic [31:0] rpc;
  logic        busy;

  int n_vec;
  int n_err;

  trap_ctrl dut (
    .i_clk           (clk),
    .i_rst_n         (rst_n),
    .i_valid         (valid),
    .i_pc            (pc),
    .i_ecall         (ecall),
    .i_ebreak        (ebreak),
    .i_illegal       (illegal),
    .i_mret          (mret),
    .i_inst_csr_we   (iwe),
    .i_inst_csr_addr (iaddr),
    .i_inst_csr_op   (iop),
    .i_inst_csr_wdata(iwdata),
    .i_mtvec         (mtvec),
    .i_mepc          (mepc),
    .i_mstatus       (mstatus),
    .o_csr_we        (csr_we),
    .o_csr_addr      (csr_addr),
    .o_csr_op        (csr_op),
    .o_csr_wdata     (csr_wdata),
    .o_stall         (stall),
    .o_redirect_valid(rv),
    .i_redirect_ready(rready),
    .o_redirect_pc   (rpc),
    .o_busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic chk_wr(input string tag,
                        input logic [11:0] a,
                        input logic [31:0] d);
    chk({tag, "_we"}, 32'(csr_we), 32'd1);
    chk({tag, "_addr"}, 32'(csr_addr), 32'(a));
    chk({tag, "_op"}, 32'(csr_op), 32'd1);
    chk({tag, "_data"}, csr_wdata, d);
    chk({tag, "_rv"}, 32'(rv), 32'd0);
  endtask

  task automatic clr_ev();
    valid   = 1'b0;
    ecall   = 1'b0;
    ebreak  = 1'b0;
    illegal = 1'b0;
    mret    = 1'b0;
    iwe     = 1'b0;
  endtask

  initial begin
    n_vec   = 0;
    n_err   = 0;
    rst_n   = 1'b0;
    pc      = '0;
    iaddr   = '0;
    iop     = '0;
    iwdata  = '0;
    mtvec   = '0;
    mepc    = '0;
    mstatus = '0;
    rready  = 1'b1;
    clr_ev();

    tick();
    tick();
    settle();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_we", 32'(csr_we), 32'd0);
    chk("rst_rv", 32'(rv), 32'd0);
    chk("rst_stall", 32'(stall), 32'd0);
    chk("rst_rpc", rpc, 32'd0);

    // pass-through
    rst_n  = 1'b1;
    tick();
    iwe    = 1'b1;
    iaddr  = 12'h305;
    iop    = 2'b01;
    iwdata = 32'h8000_0100;
    settle();
    chk("pt_we", 32'(csr_we), 32'd1);
    chk("pt_addr", 32'(csr_addr), 32'h305);
    chk("pt_op", 32'(csr_op), 32'd1);
    chk("pt_data", csr_wdata, 32'h8000_0100);
    chk("pt_stall", 32'(stall), 32'd0);

    // ecall
    tick();
    pc      = 32'h8000_0010;
    mtvec   = 32'h8000_0103;
    mstatus = 32'h0000_1808;
    valid   = 1'b1;
    ecall   = 1'b1;
    settle();
    chk("ec_acc_we", 32'(csr_we), 32'd0);
    chk("ec_acc_stall", 32'(stall), 32'd1);
    tick();
    clr_ev();
    settle();
    chk("ec_busy", 32'(busy), 32'd1);
    chk_wr("ec_mepc", 12'h341, 32'h8000_0010);
    tick();
    settle();
    chk_wr("ec_mcause", 12'h342, 32'd11);
    tick();
    settle();
    chk_wr("ec_mstatus", 12'h300, 32'h0000_1880);
    tick();
    settle();
    chk("ec_rv", 32'(rv), 32'd1);
    chk("ec_rpc", rpc, 32'h8000_0100);
    chk("ec_rd_we", 32'(csr_we), 32'd0);
    tick();
    settle();
    chk("ec_idle", 32'(busy), 32'd0);
    chk("ec_rv_off", 32'(rv), 32'd0);

    // mret with backpressure
    mepc    = 32'h8000_0014;
    mstatus = 32'h0000_1880;
    valid   = 1'b1;
    mret    = 1'b1;
    settle();
    chk("mr_acc_stall", 32'(stall), 32'd1);
    tick();
    clr_ev();
    rready = 1'b0;
    settle();
    chk_wr("mr_mstatus", 12'h300, 32'h0000_1888);
    tick();
    valid = 1'b1;
    ecall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_rv", 32'(rv), 32'd1);
      chk("bp_rpc", rpc, 32'h8000_0014);
      chk("bp_stall", 32'(stall), 32'd1);
      chk("bp_we", 32'(csr_we), 32'd0);
      tick();
    end
    rready = 1'b1;
    settle();
    chk("bp_exit_rv", 32'(rv), 32'd1);
    tick();
    clr_ev();
    settle();
    chk("bp_idle", 32'(busy), 32'd0);
    chk("bp_stall_off", 32'(stall), 32'd0);

    // priority and dropped instruction write
    pc      = 32'h8000_0020;
    mstatus = 32'h0000_0008;
    valid   = 1'b1;
    illegal = 1'b1;
    ecall   = 1'b1;
    iwe     = 1'b1;
    settle();
    chk("pr_acc_we", 32'(csr_we), 32'd0);
    tick();
    clr_ev();
    settle();
    chk_wr("pr_mepc", 12'h341, 32'h8000_0020);
    tick();
    settle();
    chk_wr("pr_mcause", 12'h342, 32'd2);
    tick();
    settle();
    chk_wr("pr_mstatus", 12'h300, 32'h0000_1880);
    tick();
    settle();
    chk("pr_rv", 32'(rv), 32'd1);
    tick();
    settle();
    chk("pr_idle", 32'(busy), 32'd0);

    // reset mid-sequence
    valid  = 1'b1;
    ebreak = 1'b1;
    tick();
    clr_ev();
    tick();
    settle();
    chk("rm_mcause_addr", 32'(csr_addr), 32'h342);
    chk("rm_mcause_data", csr_wdata, 32'd3);
    rst_n = 1'b0;
    tick();
    settle();
    chk("rm_busy", 32'(busy), 32'd0);
    chk("rm_we", 32'(csr_we), 32'd0);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      settle();
      chk("rm_no_rv", 32'(rv), 32'd0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
